// File: rtl/keep_one_in_n_unzip_if.sv
// AXI-Stream style bundle used on both sides of keep_one_in_n_unzip.
//   tdata  : payload word
//   tlast  : last beat of the packet
//   tvalid : source has a beat
//   tready : sink accepts the beat
// master drives data/last/valid and reads ready; slave is the mirror.
interface keep_one_in_n_unzip_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/keep_one_in_n_unzip.sv
// keep_one_in_n_unzip
// Receive-side 1:4 symbol unpacker for the QPSK chain. Each accepted 32-bit
// word holds four 8-bit symbols (symbol 0 in the top byte); each symbol is a
// signed 4-bit I nibble over a signed 4-bit Q nibble. One output sample is
// produced per symbol: sign-extended, shifted up by SCALE_SHIFT, packed as
// {I16, Q16}.
// Ports:
//   clk     : block clock
//   reset_n : asynchronous active-low reset
//   i_bus   : packed input stream (slave)  -- tdata/tlast/tvalid in, tready out
//   o_bus   : unpacked sample stream (master) -- tdata/tlast/tvalid out, tready in
module keep_one_in_n_unzip #(
  parameter int WIDTH       = 32,
  parameter int SYM_WIDTH   = 8,
  parameter int SCALE_SHIFT = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  keep_one_in_n_unzip_if.slave  i_bus,
  keep_one_in_n_unzip_if.master o_bus
);

  localparam int SYMS = WIDTH / SYM_WIDTH;
  localparam int HALF = SYM_WIDTH / 2;

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     hold;
  logic                 held_last;
  logic [1:0]           idx;
  logic                 ready;
  logic                 in_hs;
  logic                 out_hs;
  logic                 last_sym;
  logic [SYM_WIDTH-1:0] syms [SYMS];
  logic [SYM_WIDTH-1:0] sym;
  logic signed [15:0]   i_ext;
  logic signed [15:0]   q_ext;

  assign last_sym = (idx == 2'd3);
  assign out_hs   = (state == DRAIN) & o_bus.tready;
  assign in_hs    = i_bus.tvalid & ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_hs) state_nxt = DRAIN;
      DRAIN: if (out_hs && last_sym && !in_hs) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output / handshake logic. Ready is also offered while the last symbol
  // leaves, so a new word can load on the same edge (no bubble). Gating with
  // reset_n keeps tready low for the whole reset assertion.
  always_comb begin
    ready        = 1'b0;
    o_bus.tvalid = 1'b0;
    case (state)
      EMPTY: ready = reset_n;
      DRAIN: begin
        o_bus.tvalid = 1'b1;
        ready        = reset_n & last_sym & o_bus.tready;
      end
      default: ready = 1'b0;
    endcase
    i_bus.tready = ready;
  end

  // Hold register and sub-index. A load always wins over an advance: it can
  // only coincide with the output handshake of the last symbol.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      held_last <= 1'b0;
      idx       <= '0;
    end else if (in_hs) begin
      hold      <= i_bus.tdata;
      held_last <= i_bus.tlast;
      idx       <= '0;
    end else if (out_hs) begin
      idx       <= idx + 2'd1;
    end
  end

  // Symbol select and rescale
  always_comb begin
    for (int unsigned k = 0; k < SYMS; k++)
      syms[k] = hold[WIDTH-1-SYM_WIDTH*k -: SYM_WIDTH];
    sym          = syms[idx];
    i_ext        = 16'(signed'(sym[SYM_WIDTH-1:HALF]));
    q_ext        = 16'(signed'(sym[HALF-1:0]));
    o_bus.tdata  = {i_ext <<< SCALE_SHIFT, q_ext <<< SCALE_SHIFT};
    o_bus.tlast  = held_last & last_sym;
  end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
module tb_keep_one_in_n_unzip;

  typedef struct {
    logic [31:0]      word;
    logic             last;
    logic             use_s0;
    logic [3:0][31:0] exp;
  } vec_t;

  logic clk;
  logic reset_n;
  logic sel;
  logic [31:0] in_data;
  logic in_last;
  logic in_valid;
  logic out_ready;
  int total;
  int bad;
  vec_t vecs [4];

  keep_one_in_n_unzip_if #(.WIDTH(32)) i0 ();
  keep_one_in_n_unzip_if #(.WIDTH(32)) o0 ();
  keep_one_in_n_unzip_if #(.WIDTH(32)) i1 ();
  keep_one_in_n_unzip_if #(.WIDTH(32)) o1 ();

  keep_one_in_n_unzip #(.WIDTH(32), .SYM_WIDTH(8), .SCALE_SHIFT(12)) dut (
    .clk(clk), .reset_n(reset_n), .i_bus(i0), .o_bus(o0));

  keep_one_in_n_unzip #(.WIDTH(32), .SYM_WIDTH(8), .SCALE_SHIFT(0)) dut_s0 (
    .clk(clk), .reset_n(reset_n), .i_bus(i1), .o_bus(o1));

  assign i0.tdata  = in_data;
  assign i0.tlast  = in_last;
  assign i0.tvalid = in_valid & ~sel;
  assign i1.tdata  = in_data;
  assign i1.tlast  = in_last;
  assign i1.tvalid = in_valid & sel;
  assign o0.tready = out_ready;
  assign o1.tready = out_ready;

  logic [31:0] o_data;
  logic        o_last;
  logic        o_valid;
  logic        i_ready;
  assign o_data  = sel ? o1.tdata  : o0.tdata;
  assign o_last  = sel ? o1.tlast  : o0.tlast;
  assign o_valid = sel ? o1.tvalid : o0.tvalid;
  assign i_ready = sel ? i1.tready : i0.tready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word with o_tready held high and check its four samples.
  task automatic apply_vec(input int n);
    sel       = vecs[n].use_s0;
    in_data   = vecs[n].word;
    in_last   = vecs[n].last;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("vec_ready_empty", {31'd0, i_ready}, 32'd1);
    chk("vec_valid_empty", {31'd0, o_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("vec_valid", {31'd0, o_valid}, 32'd1);
      chk("vec_data", o_data, vecs[n].exp[k]);
      chk("vec_last", {31'd0, o_last}, {31'd0, vecs[n].last && k == 3});
      tick();
    end
    #1;
    chk("vec_valid_after", {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] words [3];
    logic [31:0] exp12 [12];
    logic [3:0][31:0] e127;
    int k;

    total = 0;
    bad   = 0;
    vecs[0] = '{word: 32'h127F80F8, last: 1'b1, use_s0: 1'b0,
                exp: {32'hF0008000, 32'h80000000, 32'h7000F000, 32'h10002000}};
    vecs[1] = '{word: 32'h7F08F000, last: 1'b0, use_s0: 1'b1,
                exp: {32'h00000000, 32'hFFFF0000, 32'h0000FFF8, 32'h0007FFFF}};
    vecs[2] = '{word: 32'h8F770099, last: 1'b1, use_s0: 1'b0,
                exp: {32'h90009000, 32'h00000000, 32'h70007000, 32'h8000F000}};
    vecs[3] = '{word: 32'h11111111, last: 1'b0, use_s0: 1'b0,
                exp: {32'h10001000, 32'h10001000, 32'h10001000, 32'h10001000}};
    e127 = vecs[0].exp;

    sel = 1'b0; reset_n = 1'b0; in_data = '0; in_last = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_ready", {31'd0, i_ready}, 32'd0);
    @(posedge clk);
    tick();
    reset_n = 1'b1;

    for (int n = 0; n < 4; n++) apply_vec(n);

    // Back-to-back words, no bubbles
    sel = 1'b0;
    words[0] = 32'h127F80F8; words[1] = 32'h11111111; words[2] = 32'h7F08F000;
    exp12 = '{32'h10002000, 32'h7000F000, 32'h80000000, 32'hF0008000,
              32'h10001000, 32'h10001000, 32'h10001000, 32'h10001000,
              32'h7000F000, 32'h00008000, 32'hF0000000, 32'h00000000};
    in_data = words[0]; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_ready0", {31'd0, i_ready}, 32'd1);
    tick();
    in_data = words[1];
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("b2b_valid", {31'd0, o_valid}, 32'd1);
      chk("b2b_data", o_data, exp12[c]);
      chk("b2b_last", {31'd0, o_last}, {31'd0, c == 11});
      chk("b2b_ready", {31'd0, i_ready}, {31'd0, c % 4 == 3});
      tick();
      if (c == 3) begin in_data = words[2]; in_last = 1'b1; end
      if (c == 7) begin in_valid = 1'b0; in_last = 1'b0; end
    end
    #1;
    chk("b2b_valid_after", {31'd0, o_valid}, 32'd0);
    tick();

    // Stalls: o_tready 1,0,0,1,0,0,...
    in_data = 32'h127F80F8; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_data = 32'h0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      out_ready = (cyc % 3 == 0);
      #1;
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_data", o_data, e127[k]);
      chk("stall_last", {31'd0, o_last}, {31'd0, k == 3});
      chk("stall_ready", {31'd0, i_ready}, {31'd0, k == 3 && out_ready});
      tick();
      if (out_ready) k++;
    end
    chk("stall_count", k, 32'd4);
    #1;
    chk("stall_valid_after", {31'd0, o_valid}, 32'd0);
    tick();

    // Reset mid-word
    in_data = 32'h127F80F8; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_before", o_data, 32'h80000000);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, i_ready}, 32'd0);
    chk("mid_rst_data", o_data, 32'd0);
    tick();
    reset_n = 1'b1;
    in_data = 32'h11111111; in_last = 1'b0; in_valid = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, i_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("mid_valid", {31'd0, o_valid}, 32'd1);
      chk("mid_data", o_data, 32'h10001000);
      chk("mid_last", {31'd0, o_last}, 32'd0);
      tick();
    end

    // Idle in EMPTY
    in_valid = 1'b0; in_data = 32'hFFFFFFFF;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("idle_valid", {31'd0, o_valid}, 32'd0);
      chk("idle_ready", {31'd0, i_ready}, 32'd1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
